// File: rtl/regfile_pkg.sv
// Shared widths and types for the multi-port register file and its in-use tracker.
package regfile_pkg;

    localparam int DEFAULT_XLEN            = 32;
    localparam int DEFAULT_NUM_REGS        = 32;
    localparam int DEFAULT_NUM_READ_PORTS  = 2;
    localparam int DEFAULT_NUM_WRITE_PORTS = 2;
    localparam int DEFAULT_ID_W            = 3;
    localparam int REG_ADDR_W              = $clog2(DEFAULT_NUM_REGS);

    typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
    typedef logic [DEFAULT_ID_W-1:0] instr_id_t;

    typedef struct packed {
        logic                    valid;
        reg_addr_t               rd_addr;
        instr_id_t               id;
        logic [DEFAULT_XLEN-1:0] data;
    } wb_port_t;

    // True when a port targets a real (non-zero) architectural register.
    function automatic logic is_real_reg(input logic [31:0] addr);
        return addr != 32'd0;
    endfunction

endpackage

// File: rtl/regfile_inuse_tracker.sv
// Per-register in-use bit and producer ID with issue > flush > retire priority.
module regfile_inuse_tracker
    import regfile_pkg::*;
#(
    parameter int NUM_REGS        = DEFAULT_NUM_REGS,
    parameter int NUM_WRITE_PORTS = DEFAULT_NUM_WRITE_PORTS,
    parameter int ID_W            = DEFAULT_ID_W,
    localparam int ADDR_W         = $clog2(NUM_REGS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic                                   issue_valid,
    input  logic [ADDR_W-1:0]                      issue_rd_addr,
    input  logic [ID_W-1:0]                        issue_id,
    input  logic [NUM_WRITE_PORTS-1:0]             wb_valid,
    input  logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0] wb_rd_addr,
    input  logic [NUM_WRITE_PORTS-1:0][ID_W-1:0]   wb_id,
    output logic [NUM_REGS-1:0]                    inuse,
    output logic [NUM_REGS-1:0][ID_W-1:0]          owner
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign inuse[gi] = 1'b0;
                assign owner[gi] = '0;
            end else begin : g_track
                logic            inuse_reg, inuse_next;
                logic [ID_W-1:0] owner_reg, owner_next;
                logic            retire_hit;

                always_comb begin
                    retire_hit = 1'b0;
                    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                        if (wb_valid[p] && wb_rd_addr[p] == ADDR_W'(gi) &&
                            wb_id[p] == owner_reg)
                            retire_hit = 1'b1;
                    end

                    inuse_next = inuse_reg;
                    owner_next = owner_reg;
                    if (issue_valid && issue_rd_addr == ADDR_W'(gi)) begin
                        inuse_next = 1'b1;
                        owner_next = issue_id;
                    end else if (flush) begin
                        inuse_next = 1'b0;
                    end else if (retire_hit) begin
                        // A retire whose ID no longer matches the owner is stale and ignored.
                        inuse_next = 1'b0;
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        inuse_reg <= 1'b0;
                        owner_reg <= '0;
                    end else begin
                        inuse_reg <= inuse_next;
                        owner_reg <= owner_next;
                    end
                end

                assign inuse[gi] = inuse_reg;
                assign owner[gi] = owner_reg;
            end
        end
    endgenerate

endmodule

// File: rtl/multi_port_register_file.sv
// Register file with N combinational read ports, M writeback ports, same-cycle
// bypass from matching writebacks and operand-conflict reporting.
module multi_port_register_file
    import regfile_pkg::*;
#(
    parameter int XLEN            = DEFAULT_XLEN,
    parameter int NUM_REGS        = DEFAULT_NUM_REGS,
    parameter int NUM_READ_PORTS  = DEFAULT_NUM_READ_PORTS,
    parameter int NUM_WRITE_PORTS = DEFAULT_NUM_WRITE_PORTS,
    parameter int ID_W            = DEFAULT_ID_W,
    localparam int ADDR_W         = $clog2(NUM_REGS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic                                   suppress_wb,
    input  logic                                   issue_valid,
    input  logic [ADDR_W-1:0]                      issue_rd_addr,
    input  logic [ID_W-1:0]                        issue_id,
    input  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0]  rs_addr,
    input  logic [NUM_READ_PORTS-1:0]              rs_uses,
    output logic [NUM_READ_PORTS-1:0][XLEN-1:0]    rs_data,
    output logic [NUM_READ_PORTS-1:0][ID_W-1:0]    rs_id,
    output logic [NUM_READ_PORTS-1:0]              rs_conflict,
    input  logic [NUM_WRITE_PORTS-1:0]             wb_valid,
    input  logic [NUM_WRITE_PORTS-1:0][ADDR_W-1:0] wb_rd_addr,
    input  logic [NUM_WRITE_PORTS-1:0][ID_W-1:0]   wb_id,
    input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]   wb_data
);

    logic [NUM_REGS-1:0]           inuse;
    logic [NUM_REGS-1:0][ID_W-1:0] owner;
    logic [NUM_REGS-1:0][XLEN-1:0] data_reg;

    regfile_inuse_tracker #(
        .NUM_REGS        (NUM_REGS),
        .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
        .ID_W            (ID_W)
    ) u_tracker (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_rd_addr (issue_rd_addr),
        .issue_id      (issue_id),
        .wb_valid      (wb_valid),
        .wb_rd_addr    (wb_rd_addr),
        .wb_id         (wb_id),
        .inuse         (inuse),
        .owner         (owner)
    );

    genvar gi;
    generate
        // Data array: the highest-indexed port targeting a register wins.
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_data
            if (gi == 0) begin : g_zero
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) data_reg[gi] <= '0;
                    else        data_reg[gi] <= '0;
                end
            end else begin : g_word
                logic            wr_en_next;
                logic [XLEN-1:0] wr_data_next;

                always_comb begin
                    wr_en_next   = 1'b0;
                    wr_data_next = data_reg[gi];
                    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                        if (wb_valid[p] && wb_rd_addr[p] == ADDR_W'(gi)) begin
                            wr_en_next   = 1'b1;
                            wr_data_next = wb_data[p];
                        end
                    end
                    wr_en_next = wr_en_next & ~suppress_wb;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)          data_reg[gi] <= '0;
                    else if (wr_en_next) data_reg[gi] <= wr_data_next;
                end
            end
        end

        // Read ports: bypass only from a writeback that retires the current owner.
        for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_read
            logic [ADDR_W-1:0] addr;
            logic              hit;
            logic [XLEN-1:0]   bypass_data;
            logic [XLEN-1:0]   data_out;
            logic              conflict_out;

            always_comb begin
                addr        = rs_addr[gi];
                hit         = 1'b0;
                bypass_data = '0;
                for (int p = NUM_WRITE_PORTS - 1; p >= 0; p--) begin
                    if (wb_valid[p] && wb_rd_addr[p] == addr && wb_id[p] == owner[addr]) begin
                        hit         = 1'b1;
                        bypass_data = wb_data[p];
                    end
                end
                hit = hit & inuse[addr];

                if (!is_real_reg(32'(addr))) data_out = '0;
                else if (hit)                data_out = bypass_data;
                else                         data_out = data_reg[addr];

                conflict_out = rs_uses[gi] & inuse[addr] & ~hit;
            end

            assign rs_data[gi]     = data_out;
            assign rs_id[gi]       = owner[addr];
            assign rs_conflict[gi] = conflict_out;
        end

        // Sanity checks on the issue/writeback protocol.
        a_no_issue_x0: assert property (@(posedge clk) disable iff (!rst_n)
            !(issue_valid && issue_rd_addr == '0));

        for (gi = 0; gi < NUM_WRITE_PORTS; gi++) begin : g_chk_a
            for (genvar gj = gi + 1; gj < NUM_WRITE_PORTS; gj++) begin : g_chk_b
                a_wb_unique: assert property (@(posedge clk) disable iff (!rst_n)
                    !(wb_valid[gi] && wb_valid[gj] && wb_rd_addr[gi] != '0 &&
                      wb_rd_addr[gi] == wb_rd_addr[gj] && wb_id[gi] == wb_id[gj]));
            end
        end
    endgenerate

endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed bench for multi_port_register_file: scoreboard, bypass, write priority, flush.
module tb_multi_port_register_file;

    localparam int XLEN = 32;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int AW   = 5;
    localparam int IDW  = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    flush, suppress_wb, issue_valid;
    logic [AW-1:0]           issue_rd_addr;
    logic [IDW-1:0]          issue_id;
    logic [NR-1:0][AW-1:0]   rs_addr;
    logic [NR-1:0]           rs_uses;
    logic [NR-1:0][XLEN-1:0] rs_data;
    logic [NR-1:0][IDW-1:0]  rs_id;
    logic [NR-1:0]           rs_conflict;
    logic [NW-1:0]           wb_valid;
    logic [NW-1:0][AW-1:0]   wb_rd_addr;
    logic [NW-1:0][IDW-1:0]  wb_id;
    logic [NW-1:0][XLEN-1:0] wb_data;

    int tests = 0;
    int fails = 0;

    multi_port_register_file dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .suppress_wb   (suppress_wb),
        .issue_valid   (issue_valid),
        .issue_rd_addr (issue_rd_addr),
        .issue_id      (issue_id),
        .rs_addr       (rs_addr),
        .rs_uses       (rs_uses),
        .rs_data       (rs_data),
        .rs_id         (rs_id),
        .rs_conflict   (rs_conflict),
        .wb_valid      (wb_valid),
        .wb_rd_addr    (wb_rd_addr),
        .wb_id         (wb_id),
        .wb_data       (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) begin
            $display("[TB] check %s = %h", tag, obs);
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; suppress_wb = 1'b0; issue_valid = 1'b0;
        issue_rd_addr = '0; issue_id = '0;
        wb_valid = '0; wb_rd_addr = '0; wb_id = '0; wb_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rd, input int id);
        issue_valid = 1'b1; issue_rd_addr = AW'(rd); issue_id = IDW'(id);
        tick();
        idle();
    endtask

    task automatic wb(input int p, input int rd, input int id, input logic [31:0] d);
        wb_valid[p] = 1'b1; wb_rd_addr[p] = AW'(rd); wb_id[p] = IDW'(id); wb_data[p] = d;
    endtask

    task automatic rd(input int k, input int addr, input logic uses);
        rs_addr[k] = AW'(addr); rs_uses[k] = uses;
        #1;
    endtask

    initial begin
        idle();
        rs_addr = '0; rs_uses = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;

        // Reset state
        rd(0, 5, 1'b1);
        chk("reset_x5_data", rs_data[0], 32'h0);
        chk("reset_x5_conflict", 32'(rs_conflict[0]), 32'h0);
        chk("reset_x5_id", 32'(rs_id[0]), 32'h0);

        // Issue then stall
        issue(3, 2);
        rd(0, 3, 1'b1);
        rd(1, 3, 1'b0);
        chk("stall_x3_conflict", 32'(rs_conflict[0]), 32'h1);
        chk("stall_x3_id", 32'(rs_id[0]), 32'h2);
        chk("stall_x3_nouse_conflict", 32'(rs_conflict[1]), 32'h0);

        // Bypass from wb port 1
        wb(1, 3, 2, 32'hDEADBEEF);
        rd(1, 3, 1'b1);
        chk("bypass_data", rs_data[0], 32'hDEADBEEF);
        chk("bypass_conflict", 32'(rs_conflict[0]), 32'h0);
        tick();
        idle();
        #1;
        chk("retired_array_data", rs_data[0], 32'hDEADBEEF);
        chk("retired_conflict", 32'(rs_conflict[0]), 32'h0);

        // Stale retire leaves the newer owner in place
        issue(7, 1);
        issue(7, 4);
        wb(0, 7, 1, 32'h55);
        rd(0, 7, 1'b1);
        chk("stale_same_cycle_conflict", 32'(rs_conflict[0]), 32'h1);
        chk("stale_same_cycle_data", rs_data[0], 32'h0);
        tick();
        idle();
        #1;
        chk("stale_conflict", 32'(rs_conflict[0]), 32'h1);
        chk("stale_owner", 32'(rs_id[0]), 32'h4);
        chk("stale_data_written", rs_data[0], 32'h55);

        // Issue beats a matching same-cycle retire
        issue(9, 3);
        issue_valid = 1'b1; issue_rd_addr = 5'd9; issue_id = 3'd5;
        wb(0, 9, 3, 32'h99);
        tick();
        idle();
        rd(0, 9, 1'b1);
        chk("issue_wins_conflict", 32'(rs_conflict[0]), 32'h1);
        chk("issue_wins_owner", 32'(rs_id[0]), 32'h5);
        chk("issue_wins_data", rs_data[0], 32'h99);

        // Dual write collision: highest port wins
        wb(0, 10, 0, 32'h11);
        wb(1, 10, 1, 32'h22);
        tick();
        idle();
        rd(0, 10, 1'b1);
        chk("collision_data", rs_data[0], 32'h22);

        // Suppressed write still retires and still bypasses
        wb(0, 11, 0, 32'hAB);
        tick();
        idle();
        issue(11, 2);
        suppress_wb = 1'b1;
        wb(0, 11, 2, 32'hCD);
        rd(0, 11, 1'b1);
        chk("suppress_bypass", rs_data[0], 32'hCD);
        tick();
        idle();
        #1;
        chk("suppress_data_kept", rs_data[0], 32'hAB);
        chk("suppress_retired", 32'(rs_conflict[0]), 32'h0);

        // Flush with simultaneous issue
        issue(1, 1);
        issue(2, 2);
        issue(3, 3);
        flush = 1'b1; issue_valid = 1'b1; issue_rd_addr = 5'd4; issue_id = 3'd4;
        tick();
        idle();
        rd(0, 1, 1'b1); rd(1, 2, 1'b1);
        chk("flush_x1_conflict", 32'(rs_conflict[0]), 32'h0);
        chk("flush_x1_owner_kept", 32'(rs_id[0]), 32'h1);
        chk("flush_x2_conflict", 32'(rs_conflict[1]), 32'h0);
        rd(0, 3, 1'b1); rd(1, 4, 1'b1);
        chk("flush_x3_conflict", 32'(rs_conflict[0]), 32'h0);
        chk("flush_x3_data_kept", rs_data[0], 32'hDEADBEEF);
        chk("flush_x4_conflict", 32'(rs_conflict[1]), 32'h1);

        // Register 0 ignores writes
        wb(0, 0, 0, 32'hFF);
        tick();
        idle();
        rd(0, 0, 1'b1);
        chk("x0_data", rs_data[0], 32'h0);
        chk("x0_conflict", 32'(rs_conflict[0]), 32'h0);

        // Asynchronous reset mid-cycle
        rd(0, 10, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_x10", rs_data[0], 32'h0);
        rd(1, 4, 1'b1);
        chk("async_reset_x4_conflict", 32'(rs_conflict[1]), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_reset_x4_id", 32'(rs_id[1]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: observed no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
